// File: rtl/bit_stuff_engine.sv
// Purpose: USB serial-path bit stuffer (mode=0) / unstuffer (mode=1) with a DEPTH-bit FIFO.
// Latency: a bit accepted in cycle N reaches the FIFO head in cycle N+1 at the earliest (no empty bypass).
// Backpressure: in_ready = ~full from registered level only; out_valid/out_bit hold while out_ready is low.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   mode             0 = stuff (insert 0 after RUN_LEN 1s), 1 = unstuff (remove it)
//   clear            synchronous flush of FIFO, run counter and any pending stuff bit
//   in_bit/in_valid/in_ready     upstream bit handshake
//   out_bit/out_valid/out_ready  downstream bit handshake
//   stuff_err        one-cycle pulse when unstuff mode sees RUN_LEN+1 consecutive 1s
//   level            FIFO occupancy (registered)

module bit_stuff_engine #(
    parameter int RUN_LEN = 6,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       clear,
    input  logic                       in_bit,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_bit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       stuff_err,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(RUN_LEN + 1);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_LEN);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [RW-1:0]    run;
    logic             mode_q;

    logic             full;
    logic             empty;
    logic             run_max;
    logic             head_bit;
    logic             in_beat;
    logic             out_beat;
    logic             push;
    logic             pop;
    logic [RW-1:0]    run_nxt;
    logic             err_nxt;

    // Status derived from registered state only.
    always_comb begin
        full     = (level == FULL_LVL);
        empty    = (level == '0);
        run_max  = (run == RUN_MAX);
        head_bit = mem[rd_ptr];
        in_ready = ~full;
    end

    // Output side. In stuff mode a saturated run forces a stuff 0 ahead of
    // the FIFO head; out_bit is gated so it reads 0 whenever nothing is valid.
    always_comb begin
        out_valid = ~empty;
        out_bit   = ~empty & head_bit;
        if (!mode_q && run_max) begin
            out_valid = 1'b1;
            out_bit   = 1'b0;
        end
    end

    always_comb begin
        in_beat  = in_valid & in_ready;
        out_beat = out_valid & out_ready;
    end

    // FIFO control and run counter. Stuff mode counts bits leaving the FIFO,
    // unstuff mode counts bits entering it. Because run only increments while
    // below RUN_MAX, it saturates without wrapping.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        run_nxt = run;
        err_nxt = 1'b0;
        if (!mode_q) begin
            push = in_beat;
            if (out_beat) begin
                if (run_max) begin
                    run_nxt = '0;                // stuff 0 emitted, head untouched
                end else begin
                    pop     = 1'b1;
                    run_nxt = head_bit ? run + RW'(1) : '0;
                end
            end
        end else begin
            pop = out_beat;
            if (in_beat) begin
                if (run_max) begin
                    run_nxt = '0;                // bit after RUN_LEN 1s is dropped
                    err_nxt = in_bit;            // ...and must have been a 0
                end else begin
                    push    = 1'b1;
                    run_nxt = in_bit ? run + RW'(1) : '0;
                end
            end
        end
        // A mode switch restarts counting and discards a pending stuff 0.
        if (mode != mode_q) begin
            run_nxt = '0;
        end
        // clear wins over every transfer in its cycle.
        if (clear) begin
            push    = 1'b0;
            pop     = 1'b0;
            run_nxt = '0;
            err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            run       <= '0;
            mode_q    <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            mode_q    <= mode;
            stuff_err <= err_nxt;
            run       <= run_nxt;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // Storage needs no reset: out_bit is gated by empty, and cleared
    // entries are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_bit;
        end
    end

endmodule

// File: tb/tb_bit_stuff_engine.sv
// Scoreboard bench for bit_stuff_engine (RUN_LEN=6, DEPTH=16).
// Inputs are driven 2 time units after the rising edge; outputs are sampled
// on the falling edge. Expected output bits are queued as stimulus is issued.

module tb_bit_stuff_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       clear = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       stuff_err;
    logic [4:0] level;

    int   vectors = 0;
    int   miscompares = 0;
    int   err_cnt = 0;
    int   max_lvl = 0;
    bit   track_lvl = 1'b0;
    logic exp_q[$];

    bit_stuff_engine #(.RUN_LEN(6), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .clear     (clear),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stuff_err (stuff_err),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every output beat.
    always @(negedge clk) begin
        logic e;
        if (!rst) begin
            if (stuff_err) err_cnt++;
            if (track_lvl && int'(level) > max_lvl) max_lvl = int'(level);
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_stream: got bit %0d, required no output", out_bit);
                end else begin
                    e = exp_q.pop_front();
                    if (out_bit !== e) begin
                        miscompares++;
                        $display("FAIL out_stream: got bit %0d, required %0d", out_bit, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic b);
        int n = 0;
        in_bit   = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: got in_ready 0, required 1 within 300 cycles");
        end else begin
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_bits(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i] == 8'h31);
    endtask

    task automatic expect_bits(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == 8'h31);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d bits outstanding, required 0", exp_q.size());
        end
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_stuff_err", int'(stuff_err), 0);
        check("rst_level", int'(level), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);

        // Stuff: 8 ones then a 0
        mode      = 1'b0;
        out_ready = 1'b1;
        expect_bits("1111110110");
        send_bits("111111110");
        drain();
        check("tx_stuff_err_count", err_cnt, 0);

        // Unstuff: 1111110 11 -> 11111111
        mode = 1'b1;
        cyc(2);
        max_lvl   = 0;
        track_lvl = 1'b1;
        expect_bits("11111111");
        send_bits("111111011");
        drain();
        track_lvl = 1'b0;
        check("rx_max_level", max_lvl, 1);
        check("rx_stuff_err_count", err_cnt, 0);

        // Unstuff error: 0 then seven 1s
        expect_bits("0111111");
        send_bits("0111111");
        send(1'b1);
        check("rx_err_pulse_high", int'(stuff_err), 1);
        cyc(1);
        check("rx_err_pulse_low", int'(stuff_err), 0);
        // run restarted: six 1s then the stuff 0 is removed without error
        expect_bits("111111");
        send_bits("1111110");
        drain();
        check("rx_err_count", err_cnt, 1);

        // Backpressure in stuff mode
        mode = 1'b0;
        cyc(2);
        out_ready = 1'b0;
        expect_bits("111111011011111100");
        send_bits("1111111101111110");
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_level", int'(level), 16);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid_hold", int'(out_valid), 1);
            check("bp_out_bit_hold", int'(out_bit), 1);
            cyc(1);
        end
        out_ready = 1'b1;
        drain();

        // Full FIFO, then streaming push+pop across the pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(i % 2 == 0);
            send(i % 2 == 0);
        end
        check("full_level", int'(level), 16);
        out_ready = 1'b1;
        for (int i = 16; i < 36; i++) begin
            exp_q.push_back(i % 2 == 0);
            send(i % 2 == 0);
            check("stream_level", int'(level), 15);
        end
        drain();

        // clear at run=5 with four bits queued, colliding with an input beat
        expect_bits("11111");
        send_bits("11111");
        drain();
        out_ready = 1'b0;
        send_bits("1111");
        check("pre_clear_level", int'(level), 4);
        clear    = 1'b1;
        in_bit   = 1'b1;
        in_valid = 1'b1;
        cyc(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_level", int'(level), 0);
        check("clear_out_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        expect_bits("111110");
        send_bits("111110");
        drain();

        // Asynchronous reset in the middle of a beat
        out_ready = 1'b0;
        send_bits("111");
        check("pre_rst_level", int'(level), 3);
        in_bit   = 1'b1;
        in_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_bit", int'(out_bit), 0);
        check("arst_stuff_err", int'(stuff_err), 0);
        check("arst_level", int'(level), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        out_ready = 1'b1;
        expect_bits("10");
        send_bits("10");
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_stuff_engine.md
Name: bit_stuff_engine

Overview:
Parametrised bidirectional bit-stuffing engine for the serial USB bit path.
- Stuff mode (TX): inserts a 0 after every RUN_LEN consecutive 1s on the output stream.
- Unstuff mode (RX): removes that 0 from the input stream and flags a stuff error when RUN_LEN+1 consecutive 1s arrive.
- Sits between the packet serializer/deserializer and the NRZI stage. Uses valid/ready handshakes on both sides and a DEPTH-bit internal FIFO.

Parameters:
- RUN_LEN, 6, consecutive-1 count that triggers insertion/removal; legal range 1..15.
- DEPTH, 16, FIFO depth in bits; power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = stuff, 1 = unstuff.
- clear  input  1  synchronous flush: empties the FIFO, zeroes the run counter, drops any pending stuff bit.
- in_bit  input  1  input data bit.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  engine accepts in_bit this cycle.
- out_bit  output  1  output data bit.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit this cycle.
- stuff_err  output  1  one-cycle pulse on an unstuff-mode violation.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst=1, asynchronous): FIFO empty, pointers 0, run=0, mode_q=0. Outputs: in_ready=1, out_valid=0, out_bit=0, stuff_err=0, level=0.
- Handshakes:
  - Input beat: in_valid & in_ready. Output beat: out_valid & out_ready.
  - in_ready = ~full, registered-state only; no combinational path from out_ready.
  - out_valid and out_bit must hold stable while out_valid & ~out_ready.
- FIFO:
  - Push and pop allowed in the same cycle at any level; level is unchanged in that case.
  - Full means level == DEPTH; empty means level == 0. No empty bypass.
  - Pointers wrap modulo DEPTH.
  - Latency: a bit accepted in cycle N is at the head no earlier than cycle N+1.
- Mode register:
  - mode_q samples mode every cycle.
  - When mode != mode_q: run is cleared, and any pending stuff is dropped.
  - Mode may only change while level == 0; otherwise FIFO contents pass unaltered under the new mode.
- Run counter: width $clog2(RUN_LEN+1); saturates at RUN_LEN and never wraps.
- Stuff mode (mode_q=0). Counting is on the output side.
  - Every input beat is pushed.
  - If run == RUN_LEN: out_valid=1 and out_bit=0 regardless of FIFO state. On the beat, no pop occurs and run becomes 0.
  - Otherwise: out_valid = ~empty and out_bit = FIFO head. On the beat the head is popped; run becomes run+1 if the bit is 1, else 0.
  - A final run of RUN_LEN 1s still emits its stuff 0 before out_valid drops.
- Unstuff mode (mode_q=1). Counting is on the input side.
  - Output is the plain FIFO head: out_valid = ~empty.
  - Input beat with run < RUN_LEN: the bit is pushed; run becomes run+1 if the bit is 1, else 0.
  - Input beat with run == RUN_LEN and bit 0: the bit is discarded (no push) and run becomes 0.
  - Input beat with run == RUN_LEN and bit 1: the bit is discarded, run becomes 0, and stuff_err pulses high the next cycle.
  - in_ready still follows ~full even when the incoming bit would be discarded.
- clear:
  - Takes priority over any beat in the same cycle; that beat's input and output transfers are dropped.
  - Next cycle: level=0 and out_valid=0.
  - stuff_err is not generated from a cleared cycle.
- Reset mid-stream: state returns immediately to reset values; no partial bit is emitted.
- level is registered and updates the cycle after a push or pop.

Test Plan:
- Stuff, RUN_LEN=6. Push 8 ones then a 0, out_ready=1 -> out stream 1111110 110 (10 bits); exactly one inserted 0 after the 6th 1; stuff_err never asserted.
- Unstuff, RUN_LEN=6. Feed 1111110 11 -> output 11111111; the 0 is removed; level never exceeds 2 with out_ready=1.
- Unstuff error. Feed 7 ones -> output 6 ones; stuff_err pulses for exactly one cycle, one cycle after the 7th beat; run restarts at 0.
- Backpressure, DEPTH=16, stuff mode, out_ready=0:
  - Push 16 bits -> in_ready=0 and level=16; out_valid and out_bit stable.
  - Release out_ready -> all 16 bits plus the required stuff 0s emerge in order.
- Simultaneous push and pop at full, then with wrap past index DEPTH-1 -> level constant and data order preserved.
- clear and rst: assert clear mid-run at run=5 with the FIFO holding 4 bits -> next cycle level=0 and out_valid=0, and a following 1 is not stuffed early. Assert rst asynchronously mid-beat -> all outputs take their reset values immediately.
